// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the reverse-order AES-128 key schedule.
package aes_pkg;

  localparam int         AES_NR    = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_LAST = 8'h36;
  localparam logic [8:0] AES_POLY  = 9'h11b;

  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY[7:0] : 8'h00);
  endfunction

  // Undoes xtime: an odd value can only come from a reduced product.
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    logic [7:0] r;
    r = x[0] ? (((x ^ AES_POLY[7:0]) >> 1) | 8'h80) : (x >> 1);
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_rev_key_sched_if.sv
// Load / round-key handshake bundle between the key scheduler and its consumer.
interface aes_rev_key_sched_if;
  logic [127:0] key_in;
  logic         key_load;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         done;

  modport master (
    output key_in, key_load, rk_ready,
    input  busy, rk_valid, rk_out, rk_round, rk_last, done
  );

  modport slave (
    input  key_in, key_load, rk_ready,
    output busy, rk_valid, rk_out, rk_round, rk_last, done
  );
endinterface

// File: rtl/aes_sub_word.sv
// Combinational AES SubWord: four forward S-boxes built from GF(2^8) inversion plus the affine map.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  // Multiplicative inverse as x^254 (maps 0 to 0 as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, x);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, x);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, x);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, x);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, x);
    return gf_mul(x127, x127);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign word_o[8*i +: 8] = sbox(word_i[8*i +: 8]);
  end

endmodule

// File: rtl/aes_rev_key_sched.sv
// Reverse-order AES-128 round-key generator: forward schedule to round 10, then emits 10..0.
// Optional round-10 cache enabled by defining AES_RKEY_CACHE_EN.
module aes_rev_key_sched
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int KEY_W = 128
) (
  input  logic               clk,
  input  logic               rst,
  aes_rev_key_sched_if.slave rk_if
);

  localparam logic [3:0] NR_L = 4'(NR);

  state_e           state_q;
  logic [KEY_W-1:0] key_q;
  logic [7:0]       rc_q;
  logic [3:0]       cnt_q;
  logic [3:0]       rk_round_q;
  logic             busy_q;
  logic             rk_valid_q;
  logic             rk_last_q;
  logic             done_q;

`ifdef AES_RKEY_CACHE_EN
  logic [KEY_W-1:0] last_key_q;
  logic [KEY_W-1:0] cache_key_q;
  logic             cache_vld_q;
`endif

  logic [31:0]      w0, w1, w2, w3;
  logic [31:0]      v1, v2, v3;
  logic [31:0]      f0, f1, f2, f3;
  logic [31:0]      sub_in, sub_out, t;
  logic [KEY_W-1:0] fwd_key_d;
  logic [KEY_W-1:0] bwd_key_d;
  logic             hs;

  assign {w0, w1, w2, w3} = key_q;
  assign v3 = w3 ^ w2;
  assign v2 = w2 ^ w1;
  assign v1 = w1 ^ w0;

  // One SubWord serves both directions; FWD feeds w3, EMIT feeds the recovered v3.
  assign sub_in = (state_q == FWD) ? rot_word(w3) : rot_word(v3);

  aes_sub_word u_sub_word (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  assign t         = sub_out ^ {rc_q, 24'h000000};
  assign f0        = w0 ^ t;
  assign f1        = w1 ^ f0;
  assign f2        = w2 ^ f1;
  assign f3        = w3 ^ f2;
  assign fwd_key_d = {f0, f1, f2, f3};
  assign bwd_key_d = {w0 ^ t, v1, v2, v3};
  assign hs        = rk_valid_q & rk_if.rk_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      rc_q        <= RCON_INIT;
      cnt_q       <= 4'd0;
      rk_round_q  <= 4'd0;
      busy_q      <= 1'b0;
      rk_valid_q  <= 1'b0;
      rk_last_q   <= 1'b0;
      done_q      <= 1'b0;
`ifdef AES_RKEY_CACHE_EN
      cache_vld_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rk_if.key_load) begin
            busy_q <= 1'b1;
            rc_q   <= RCON_INIT;
            cnt_q  <= 4'd1;
`ifdef AES_RKEY_CACHE_EN
            if (cache_vld_q && (rk_if.key_in == last_key_q)) begin
              key_q      <= cache_key_q;
              rc_q       <= RCON_LAST;
              rk_valid_q <= 1'b1;
              rk_round_q <= NR_L;
              rk_last_q  <= 1'b0;
              state_q    <= EMIT;
            end else begin
              key_q       <= rk_if.key_in;
              last_key_q  <= rk_if.key_in;
              cache_vld_q <= 1'b0;
              state_q     <= FWD;
            end
`else
            key_q   <= rk_if.key_in;
            state_q <= FWD;
`endif
          end
        end
        FWD: begin
          key_q <= fwd_key_d;
          if (cnt_q == NR_L) begin
            // rc stays at the last constant: it is the first one the backward walk needs.
            rk_valid_q <= 1'b1;
            rk_round_q <= NR_L;
            rk_last_q  <= 1'b0;
            state_q    <= EMIT;
`ifdef AES_RKEY_CACHE_EN
            cache_key_q <= fwd_key_d;
            cache_vld_q <= 1'b1;
`endif
          end else begin
            rc_q  <= xtime(rc_q);
            cnt_q <= cnt_q + 4'd1;
          end
        end
        EMIT: begin
          if (hs) begin
            if (rk_round_q == 4'd0) begin
              rk_valid_q <= 1'b0;
              rk_last_q  <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= IDLE;
            end else begin
              key_q      <= bwd_key_d;
              rc_q       <= inv_xtime(rc_q);
              rk_round_q <= rk_round_q - 4'd1;
              rk_last_q  <= (rk_round_q == 4'd1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rk_if.busy     = busy_q;
  assign rk_if.rk_valid = rk_valid_q;
  assign rk_if.rk_out   = key_q;
  assign rk_if.rk_round = rk_round_q;
  assign rk_if.rk_last  = rk_last_q;
  assign rk_if.done     = done_q;

endmodule

// File: tb/tb_aes_rev_key_sched.sv
// Directed bench for aes_rev_key_sched with an independent key-expansion model and scoreboard.
module tb_aes_rev_key_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_rev_key_sched_if bus ();

  aes_rev_key_sched dut (
    .clk   (clk),
    .rst   (rst),
    .rk_if (bus)
  );

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
    logic         last;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] exp_rk[0:10];
  int           n_err = 0;
  int           n_chk = 0;
  logic [127:0] c_key = '0;
  bit           c_vld = 1'b0;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference GF arithmetic: Horner-form multiply, inverse by exhaustive search.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      if (a[i]) p = p ^ b;
    end
    return p;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    inv = 8'h00;
    c   = 8'h63;
    if (x != 8'h00)
      for (int k = 1; k < 256; k++)
        if (m_mul(x, 8'(k)) == 8'h01) inv = 8'(k);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w[0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0]), m_sbox(t[31:24])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},     bus.busy,     1'b0);
    chk({tag, "_valid"},    bus.rk_valid, 1'b0);
    chk({tag, "_last"},     bus.rk_last,  1'b0);
    chk({tag, "_done"},     bus.done,     1'b0);
    chk({tag, "_round"},    bus.rk_round, 4'd0);
    chk({tag, "_rk_out"},   bus.rk_out,   128'h0);
  endtask

  // Load one key and consume all 11 round keys; ready_mode 0 = always ready, 1 = random.
  task automatic run_key(input string tag, input logic [127:0] key, input int ready_mode,
                         input bit spurious, input logic [127:0] other_key);
    int   cyc, first_valid, last_hs, got, exp_lat;
    bit   prev_stall, rdy;
    logic [127:0] prev_out;
    logic [3:0]   prev_rnd;
    exp_t e;
`ifdef AES_RKEY_CACHE_EN
    exp_lat = (c_vld && key == c_key) ? 1 : 11;
    c_key   = key;
    c_vld   = 1'b1;
`else
    exp_lat = 11;
`endif
    expand(key);
    for (int r = 10; r >= 0; r--) sb_q.push_back('{rnd: 4'(r), key: exp_rk[r], last: (r == 0)});
    @(negedge clk);
    bus.key_in   = key;
    bus.key_load = 1'b1;
    bus.rk_ready = 1'b0;
    @(negedge clk);
    bus.key_in  = spurious ? other_key : ~key;
    chk({tag, "_busy_after_load"}, bus.busy, 1'b1);
    cyc = 1; first_valid = -1; last_hs = -1; got = 0; prev_stall = 1'b0;
    prev_out = '0; prev_rnd = '0;
    while (got < 11 && cyc < 400) begin
      bus.key_load = spurious && (cyc == 4 || cyc == exp_lat + 2);
      if (bus.rk_valid && first_valid < 0) begin
        first_valid = cyc;
        chk({tag, "_first_valid_cycle"}, 128'(cyc), 128'(exp_lat));
      end
      if (prev_stall) begin
        chk({tag, "_stall_hold_out"},   bus.rk_out,   prev_out);
        chk({tag, "_stall_hold_round"}, bus.rk_round, prev_rnd);
      end
      rdy = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.rk_ready = rdy;
      if (bus.rk_valid && rdy) begin
        e = sb_q.pop_front();
        chk({tag, "_round"},  bus.rk_round, e.rnd);
        chk({tag, "_rk_out"}, bus.rk_out,   e.key);
        chk({tag, "_last"},   bus.rk_last,  e.last);
        got++;
        last_hs = cyc;
      end
      prev_stall = bus.rk_valid && !rdy;
      prev_out   = bus.rk_out;
      prev_rnd   = bus.rk_round;
      @(negedge clk);
      cyc++;
    end
    bus.key_load = 1'b0;
    bus.rk_ready = 1'b0;
    chk({tag, "_keys_received"}, 128'(got), 128'd11);
    if (got < 11) sb_q.delete();
    if (ready_mode == 0) chk({tag, "_back_to_back"}, 128'(last_hs - first_valid), 128'd10);
    chk({tag, "_done_pulse"},   bus.done,     1'b1);
    chk({tag, "_valid_after"},  bus.rk_valid, 1'b0);
    chk({tag, "_busy_after"},   bus.busy,     1'b0);
    @(negedge clk);
    chk({tag, "_done_cleared"}, bus.done,     1'b0);
  endtask

  // Load a key, then hit reset either at cycle 5 (FWD) or when round 6 is presented.
  task automatic run_abort(input string tag, input logic [127:0] key, input bit in_emit);
    int cyc;
    bit found;
    @(negedge clk);
    bus.key_in   = key;
    bus.key_load = 1'b1;
    bus.rk_ready = 1'b0;
    @(negedge clk);
    bus.key_load = 1'b0;
    cyc = 1;
    if (!in_emit) begin
      while (cyc < 5) begin
        @(negedge clk);
        cyc++;
      end
      chk({tag, "_busy_in_fwd"}, bus.busy, 1'b1);
    end else begin
      found = 1'b0;
      while (cyc < 100 && !found) begin
        if (bus.rk_valid && bus.rk_round == 4'd6) found = 1'b1;
        else begin
          bus.rk_ready = 1'b1;
          @(negedge clk);
          cyc++;
        end
      end
      chk({tag, "_reached_round6"}, found, 1'b1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.rk_ready = 1'b0;
    chk_reset_vals(tag);
    @(negedge clk);
    chk({tag, "_no_done"}, bus.done, 1'b0);
    chk({tag, "_idle"},    bus.busy, 1'b0);
    c_vld = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.key_in   = '0;
    bus.key_load = 1'b0;
    bus.rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // Model agrees with the published FIPS-197 expansion values.
    expand(K1);
    chk("model_k1_r10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_k1_r1",  exp_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_k1_r0",  exp_rk[0],  K1);
    expand(K2);
    chk("model_k2_r10", exp_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    run_key("t1_fips",      K1, 0, 1'b0, '0);
    run_key("t2_ready1",    K2, 0, 1'b0, '0);
    run_key("t3_backpress", K1, 1, 1'b0, '0);
    run_key("t4_spurious",  K1, 1, 1'b1, K2);
    run_abort("t5_rst_fwd",  K1, 1'b0);
    run_abort("t5_rst_emit", K2, 1'b1);
    run_key("t5_after_rst", K2, 0, 1'b0, '0);
`ifdef AES_RKEY_CACHE_EN
    run_key("t6_a_cold", K1, 0, 1'b0, '0);
    run_key("t6_a_hit",  K1, 0, 1'b0, '0);
    run_key("t6_b_cold", K2, 1, 1'b0, '0);
    run_key("t6_a_cold2", K1, 0, 1'b0, '0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
